// File: rtl/simpleton_mem_responder_if.sv
// simpleton_mem_responder_if: req/ack memory bus between a Simpleton core and its memory.
interface simpleton_mem_responder_if;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       err;
  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/simpleton_mem_responder.sv
// simpleton_mem_responder: handshaked ROM/RAM target with wait states and a RAM[0] debug tap.
module simpleton_mem_responder #(
  parameter int WAIT_CYCLES = 1,
  parameter int RAM_DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  simpleton_mem_responder_if.slave   bus,
  output logic [7:0]                 mem128_o
);
  localparam int AW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  localparam logic [7:0] ROM [8] = '{8'h20, 8'h05, 8'h30, 8'h05, 8'h10, 8'h80, 8'hF0, 8'h0F};
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d, err_q, err_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] ram_q [RAM_DEPTH];
  logic       we_c, in_ram, bad, enter_ack;
  logic [7:0] addr_c, wdata_c, rom_c, rd_c;
  // In IDLE a zero-wait request completes on the capture edge, so decode the live bus there
  always_comb begin
    we_c      = state_q == IDLE ? bus.we    : we_q;
    addr_c    = state_q == IDLE ? bus.addr  : addr_q;
    wdata_c   = state_q == IDLE ? bus.wdata : wdata_q;
    in_ram    = addr_c[7] && ({1'b0, addr_c[6:0]} < 8'(RAM_DEPTH));
    rom_c     = addr_c[7:3] == 5'd0 ? ROM[addr_c[2:0]] : 8'h00;
    rd_c      = we_c ? 8'h00 : !addr_c[7] ? rom_c : in_ram ? ram_q[addr_c[AW-1:0]] : 8'h00;
    bad       = addr_c[7] ? !in_ram : we_c;
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    enter_ack = 1'b0;
    case (state_q)
      IDLE: if (bus.req) begin
        we_d      = bus.we;
        addr_d    = bus.addr;
        wdata_d   = bus.wdata;
        cnt_d     = 4'(WAIT_CYCLES);
        enter_ack = WAIT_CYCLES == 0;
        state_d   = WAIT_CYCLES == 0 ? ACK : WAIT;
      end
      WAIT: begin
        cnt_d     = cnt_q - 4'd1;
        enter_ack = cnt_q == 4'd1;
        state_d   = enter_ack ? ACK : WAIT;
      end
      ACK:     state_d = bus.req ? ACK : IDLE;
      default: state_d = IDLE;
    endcase
    rdata_d = enter_ack ? rd_c : rdata_q;
    err_d   = enter_ack && bad;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // The write lands only on the edge entering ACK, so a held req cannot re-commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= 8'h00;
    end else if (enter_ack && we_c && in_ram) begin
      ram_q[addr_c[AW-1:0]] <= wdata_c;
    end
  end
  assign bus.ack   = state_q == ACK;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign mem128_o  = ram_q[0];
endmodule

// File: tb/tb_simpleton_mem_responder.sv
// tb_simpleton_mem_responder: zero-wait and two-wait responders on one shared request stream vs a memory model.
module tb_simpleton_mem_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, we = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic [7:0] m0, m2;
  logic [7:0] ram_m [16];
  int         n_chk = 0, n_pass = 0;
  simpleton_mem_responder_if b0();
  simpleton_mem_responder_if b2();
  assign b0.req = req;
  assign b0.we = we;
  assign b0.addr = addr;
  assign b0.wdata = wdata;
  assign b2.req = req;
  assign b2.we = we;
  assign b2.addr = addr;
  assign b2.wdata = wdata;
  simpleton_mem_responder #(.WAIT_CYCLES(0), .RAM_DEPTH(16)) u0 (.clk(clk), .rst(rst), .bus(b0), .mem128_o(m0));
  simpleton_mem_responder #(.WAIT_CYCLES(2), .RAM_DEPTH(16)) u2 (.clk(clk), .rst(rst), .bus(b2), .mem128_o(m2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  function automatic logic [7:0] rom_m(input logic [7:0] a);
    case (a)
      8'h00: return 8'h20;
      8'h01: return 8'h05;
      8'h02: return 8'h30;
      8'h03: return 8'h05;
      8'h04: return 8'h10;
      8'h05: return 8'h80;
      8'h06: return 8'hF0;
      8'h07: return 8'h0F;
      default: return 8'h00;
    endcase
  endfunction
  task automatic check_reset(input string tag);
    chk({tag, "_ack0"}, b0.ack, 0);
    chk({tag, "_ack2"}, b2.ack, 0);
    chk({tag, "_rd0"}, b0.rdata, 0);
    chk({tag, "_rd2"}, b2.rdata, 0);
    chk({tag, "_err0"}, b0.err, 0);
    chk({tag, "_err2"}, b2.err, 0);
    chk({tag, "_m0"}, m0, 0);
    chk({tag, "_m2"}, m2, 0);
  endtask
  task automatic trans(input logic w, input logic [7:0] a, input logic [7:0] d, input int hold);
    int lat0 = -1, lat2 = -1, e0 = 0, e2 = 0, n = 0;
    logic ok_ram, bad;
    logic [7:0] exp;
    ok_ram = a[7] && a[6:0] < 7'd16;
    bad = a[7] ? !ok_ram : w;
    exp = w ? 8'h00 : !a[7] ? rom_m(a) : ok_ram ? ram_m[a[3:0]] : 8'h00;
    if (w && ok_ram) ram_m[a[3:0]] = d;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    while ((lat0 < 0 || lat2 < 0) && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        we = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      end
      if (b0.ack && lat0 < 0) lat0 = n;
      if (b2.ack && lat2 < 0) lat2 = n;
      e0 += int'(b0.err);
      e2 += int'(b2.err);
    end
    repeat (hold) begin
      @(negedge clk);
      e0 += int'(b0.err);
      e2 += int'(b2.err);
      chk("hold_ack2", b2.ack, 1);
    end
    chk("lat0", lat0, 1);
    chk("lat2", lat2, 3);
    chk("rdata0", b0.rdata, exp);
    chk("rdata2", b2.rdata, exp);
    req = 1'b0;
    @(negedge clk);
    e0 += int'(b0.err);
    e2 += int'(b2.err);
    chk("rel_ack0", b0.ack, 0);
    chk("rel_ack2", b2.ack, 0);
    chk("err0_pulses", e0, int'(bad));
    chk("err2_pulses", e2, int'(bad));
    chk("mem128_0", m0, ram_m[0]);
    chk("mem128_2", m2, ram_m[0]);
  endtask
  initial begin
    foreach (ram_m[i]) ram_m[i] = 8'h00;
    #1 check_reset("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    trans(1'b0, 8'h01, 8'h00, 0);
    trans(1'b1, 8'h80, 8'h0A, 0);
    trans(1'b0, 8'h80, 8'h00, 0);
    trans(1'b0, 8'h8F, 8'h00, 0);
    trans(1'b1, 8'h03, 8'hFF, 0);
    trans(1'b0, 8'h03, 8'h00, 0);
    trans(1'b0, 8'h90, 8'h00, 1);
    trans(1'b1, 8'h81, 8'h33, 6);
    trans(1'b0, 8'h81, 8'h00, 2);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 8'h80; wdata = 8'h77;
    @(negedge clk);
    chk("rstw_e0_ack2", b2.ack, 0);
    chk("rstw_e0_m0", m0, 8'h77);
    @(negedge clk);
    chk("rstw_e1_ack2", b2.ack, 0);
    chk("rstw_e1_m2", m2, 8'h0A);
    rst = 1'b1;
    #1 check_reset("midrst");
    foreach (ram_m[i]) ram_m[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    chk("rstw_after_ack2", b2.ack, 0);
    chk("rstw_after_m2", m2, 0);
    trans(1'b1, 8'h80, 8'h77, 0);
    for (int k = 0; k < 40; k++) begin
      logic [7:0] a;
      case ($urandom_range(0, 3))
        0: a = 8'($urandom_range(0, 7));
        1: a = 8'($urandom_range(8, 127));
        2: a = 8'(8'h80 + $urandom_range(0, 15));
        default: a = 8'($urandom_range(144, 255));
      endcase
      trans(1'($urandom_range(0, 1)), a, 8'($urandom), int'($urandom_range(0, 3)));
    end
    for (int k = 0; k < 16; k++) trans(1'b0, 8'(8'h80 + k), 8'h00, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/simpleton_mem_responder.md
# simpleton_mem_responder

Memory-side responder for the Simpleton CPU bus, decoupled by a four-phase req/ack handshake so memory latency can exceed one cycle. It decodes the 8-bit address into the fixed program ROM (0x00–0x7F) and a small RAM window starting at 0x80. It inserts programmable wait states, commits writes exactly once per transaction, and exports RAM word 0 for the 7-segment debug display. It is the target-end counterpart of a handshaking Simpleton core's memory port.

## Interface
- WAIT_CYCLES, 1, wait states inserted between request capture and ack; legal 0..15.
- RAM_DEPTH, 16, number of RAM bytes at 0x80..0x80+RAM_DEPTH-1; legal 1..128.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request; held high by the initiator until ack is seen, then dropped.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  8  byte address; sampled with req.
- wdata  in  8  write data; sampled with req.
- ack  out  1  acknowledge; high from response until req falls.
- rdata  out  8  read data, valid while ack=1.
- err  out  1  one-cycle pulse: write to ROM, or access beyond RAM window.
- mem128  out  8  current contents of RAM[0] (address 0x80).

## Operation
- ROM contents, combinational on captured address:
  - 0x00=0x20, 0x01=0x05, 0x02=0x30, 0x03=0x05, 0x04=0x10, 0x05=0x80, 0x06=0xF0, 0x07=0x0F.
  - 0x08–0x7F read 0x00.
- RAM: addr[7]=1 and addr-0x80 < RAM_DEPTH. Addresses at or above 0x80+RAM_DEPTH are out of range: read 0x00, write ignored, err pulsed.
- ROM writes are ignored and pulse err; rdata=0x00 for any write transaction.
- FSM states IDLE, WAIT, ACK.
  - IDLE: if req=1, latch we/addr/wdata, load counter=WAIT_CYCLES. Go to ACK if WAIT_CYCLES=0, else go to WAIT.
  - WAIT: decrement counter; at counter=1, go to ACK. req/addr/we/wdata changes are ignored (latched copy used).
  - ACK: ack=1; if req=0, go to IDLE (ack low next cycle). Otherwise stay.
- On the edge entering ACK:
  - rdata is registered.
  - A RAM write commits; it commits once, regardless of how long req stays high.
  - err is pulsed for exactly that one cycle, if applicable.
- A new request is recognized only in IDLE, so at least one idle cycle separates transactions.
- Counter is 4 bits; no wrap, since it is reloaded per transaction.

## Timing
- Reset (async) forces:
  - state=IDLE, ack=0, rdata=0x00, err=0, counter=0.
  - All RAM bytes 0x00, so mem128=0x00.
- Latency: req first sampled high at edge E0 gives ack=1 after edge E0+WAIT_CYCLES. With WAIT_CYCLES=0, ack rises after E0 itself.
- Release: req sampled low at edge Ek while in ACK gives ack=0 after Ek. req may then be reasserted, and is sampled at Ek+1 at the earliest.
- mem128 updates after the same edge that commits a write to 0x80.
- rst asserted in WAIT: the transaction is aborted, nothing is committed, and the initiator must re-issue.
- rst asserted in ACK: ack drops immediately; the write has already committed, and the RAM is then cleared by reset.
- req dropped during WAIT (protocol violation): the transaction still completes. ACK is entered, then IDLE is entered on the next edge, since req=0.

## Test plan
- Reset: pulse rst mid-simulation with all inputs X-free → ack=0, rdata=0x00, err=0, mem128=0x00 immediately; no clk edge required.
- ROM read, WAIT_CYCLES=2: req=1 we=0 addr=0x01 at E0 → ack high after E2, rdata=0x05; drop req → ack low after the next edge.
- RAM write/read, WAIT_CYCLES=0:
  - Write 0x80 data 0x0A → ack after E0, mem128=0x0A.
  - Read 0x80 → rdata=0x0A.
  - Read 0x8F → rdata=0x00.
- Illegal accesses, RAM_DEPTH=16:
  - Write 0x03 data 0xFF → one-cycle err; a subsequent read of 0x03 returns 0x05.
  - Read 0x90 → rdata=0x00 with err pulse.
- Held request: write 0x81 data 0x33, req held high 6 cycles after ack → ack stays high, err never pulses, a single commit occurs, and read 0x81=0x33.
- Reset mid-WAIT, WAIT_CYCLES=5: write 0x80 data 0x77, rst at E2 → ack never rises, mem128 stays 0x00; the re-issued request completes normally.
